// File: rtl/neuron_pkg.sv
// Shared types and default fixed-point constants for the LIF neuron.
// All constants are unsigned with 8 fractional bits.
package neuron_pkg;

  typedef enum logic [1:0] {
    StIntegrate = 2'd0,
    StFire      = 2'd1,
    StRefract   = 2'd2
  } neuron_state_e;

  localparam int unsigned DefW         = 14;
  localparam int unsigned DefFrac      = 8;
  localparam int unsigned DefWeightE   = 32'h800;  // 8.0
  localparam int unsigned DefWeightI   = 32'h800;  // 8.0
  localparam int unsigned DefDecayE    = 32'h9A;   // 0.6
  localparam int unsigned DefDecayI    = 32'hCD;   // 0.8
  localparam int unsigned DefDecayV    = 32'hE6;   // 0.9
  localparam int unsigned DefThreshold = 32'h1400; // 20.0
  localparam int unsigned DefVReset    = 0;
  localparam int unsigned DefTRef      = 3;

endpackage

// File: rtl/decay_accum.sv
// Conductance register: decays by a fixed-point factor each enabled cycle and
// accumulates weight * popcount(spikes), saturating at the top of the datapath.
module decay_accum #(
  parameter int unsigned Width  = 14,
  parameter int unsigned Frac   = 8,
  parameter int unsigned NumIn  = 8,
  parameter int unsigned Decay  = 32'h9A,
  parameter int unsigned Weight = 32'h800
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [NumIn-1:0] spikes_i,
  output logic [Width-1:0] g_o
);

  localparam int unsigned PopW = $clog2(NumIn + 1);
  // Wide enough for the full decay product plus the weighted popcount.
  localparam int unsigned SumW = 2 * Width + PopW + 1;

  logic [Width-1:0] g_q, g_d;
  logic [PopW-1:0]  pop;
  logic [SumW-1:0]  decayed, weighted, sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      pop = pop + PopW'(spikes_i[i]);
    end
    decayed  = (SumW'(g_q) * SumW'(Decay)) >> Frac;
    weighted = SumW'(Weight) * SumW'(pop);
    sum      = decayed + weighted;
    if (sum > {{(SumW - Width){1'b0}}, {Width{1'b1}}}) begin
      g_d = '1;
    end else begin
      g_d = sum[Width-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      g_q <= '0;
    end else if (en_i) begin
      g_q <= g_d;
    end
  end

  assign g_o = g_q;

endmodule

// File: rtl/param_lif_neuron.sv
// Parameterised leaky integrate-and-fire neuron with conductance-based
// excitatory/inhibitory inputs, single-cycle fire pulse and refractory period.
module param_lif_neuron
  import neuron_pkg::*;
#(
  parameter int unsigned N_EXC     = 8,
  parameter int unsigned N_INH     = 8,
  parameter int unsigned W         = DefW,
  parameter int unsigned FRAC      = DefFrac,
  parameter int unsigned WEIGHT_E  = DefWeightE,
  parameter int unsigned WEIGHT_I  = DefWeightI,
  parameter int unsigned DECAY_E   = DefDecayE,
  parameter int unsigned DECAY_I   = DefDecayI,
  parameter int unsigned DECAY_V   = DefDecayV,
  parameter int unsigned THRESHOLD = DefThreshold,
  parameter int unsigned V_RESET   = DefVReset,
  parameter int unsigned T_REF     = DefTRef,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_EXC-1:0] i_excitatory,
  input  logic [N_INH-1:0] i_inhibitory,
  input  logic             i_enable,
  output logic             o_spike,
  output logic             o_refractory,
  output logic [W-1:0]     o_membrane,
  output logic [CNT_W-1:0] o_spike_count
);

  localparam int unsigned VW = 2 * W + 1;

  logic [W-1:0] ge, gi;

  decay_accum #(
    .Width  (W),
    .Frac   (FRAC),
    .NumIn  (N_EXC),
    .Decay  (DECAY_E),
    .Weight (WEIGHT_E)
  ) u_exc_accum (
    .clk_i    (clk),
    .rst_ni   (reset),
    .en_i     (i_enable),
    .spikes_i (i_excitatory),
    .g_o      (ge)
  );

  decay_accum #(
    .Width  (W),
    .Frac   (FRAC),
    .NumIn  (N_INH),
    .Decay  (DECAY_I),
    .Weight (WEIGHT_I)
  ) u_inh_accum (
    .clk_i    (clk),
    .rst_ni   (reset),
    .en_i     (i_enable),
    .spikes_i (i_inhibitory),
    .g_o      (gi)
  );

  neuron_state_e    state_q, state_d;
  logic [W-1:0]     v_q, v_d;
  logic [7:0]       ref_cnt_q, ref_cnt_d;
  logic             spike_q, spike_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [VW-1:0] v_decay, v_pos, gi_ext, v_diff;
  logic [W-1:0]  v_next;

  // Membrane candidate from registered conductances; negative clamps to zero.
  always_comb begin
    v_decay = (VW'(v_q) * VW'(DECAY_V)) >> FRAC;
    v_pos   = v_decay + VW'(ge);
    gi_ext  = VW'(gi);
    v_diff  = v_pos - gi_ext;
    if (v_pos <= gi_ext) begin
      v_next = '0;
    end else if (v_diff > {{(VW - W){1'b0}}, {W{1'b1}}}) begin
      v_next = '1;
    end else begin
      v_next = v_diff[W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    ref_cnt_d = ref_cnt_q;
    spike_d   = spike_q;
    count_d   = count_q;
    if (i_enable) begin
      spike_d = 1'b0;
      unique case (state_q)
        StIntegrate: begin
          if (v_next >= W'(THRESHOLD)) begin
            v_d     = W'(V_RESET);
            spike_d = 1'b1;
            state_d = StFire;
            count_d = count_q + CNT_W'(1);
          end else begin
            v_d = v_next;
          end
        end
        StFire: begin
          v_d = W'(V_RESET);
          if (T_REF == 0) begin
            state_d = StIntegrate;
          end else begin
            state_d   = StRefract;
            ref_cnt_d = 8'(T_REF);
          end
        end
        StRefract: begin
          v_d = W'(V_RESET);
          if (ref_cnt_q <= 8'd1) begin
            state_d   = StIntegrate;
            ref_cnt_d = '0;
          end else begin
            ref_cnt_d = ref_cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = StIntegrate;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIntegrate;
      v_q       <= W'(V_RESET);
      ref_cnt_q <= '0;
      spike_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      ref_cnt_q <= ref_cnt_d;
      spike_q   <= spike_d;
      count_q   <= count_d;
    end
  end

  // spike_q tracks FIRE; gating keeps the pulse silent while the neuron is paused.
  assign o_spike       = spike_q & i_enable;
  assign o_refractory  = (state_q == StRefract);
  assign o_membrane    = v_q;
  assign o_spike_count = count_q;

endmodule

// File: doc/param_lif_neuron.md
PARAM_LIF_NEURON -- requirements
Module: param_lif_neuron

Interface
REQ-001 Parameters; all fixed-point values are unsigned with FRAC fractional bits:
- N_EXC, default 8: number of excitatory inputs.
- N_INH, default 8: number of inhibitory inputs.
- W, default 14: datapath width.
- FRAC, default 8: fractional bits.
- WEIGHT_E, default 14'h800: weight added per excitatory spike (8.0).
- WEIGHT_I, default 14'h800: weight added per inhibitory spike (8.0).
- DECAY_E, default 14'h9A: excitatory conductance decay factor (0.6).
- DECAY_I, default 14'hCD: inhibitory conductance decay factor (0.8).
- DECAY_V, default 14'hE6: membrane decay factor (0.9).
- THRESHOLD, default 14'h1400: firing threshold (20.0).
- V_RESET, default 0: post-spike membrane value.
- T_REF, default 3: refractory cycles, range 0..255.
- CNT_W, default 16: spike counter width.

REQ-002 Ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- i_excitatory, input, N_EXC: excitatory spike inputs, sampled every cycle.
- i_inhibitory, input, N_INH: inhibitory spike inputs, sampled every cycle.
- i_enable, input, 1: when low, all state registers hold.
- o_spike, output, 1: registered single-cycle fire pulse.
- o_refractory, output, 1: high while in REFRACT.
- o_membrane, output, W: current membrane register value.
- o_spike_count, output, CNT_W: total fires, wrapping.

Function
REQ-003 Each enabled cycle, ge <= sat(floor(ge*DECAY_E >> FRAC) + WEIGHT_E*popcount(i_excitatory)).
REQ-004 Each enabled cycle, gi <= sat(floor(gi*DECAY_I >> FRAC) + WEIGHT_I*popcount(i_inhibitory)).
REQ-005 sat() clamps to 2^W-1; all intermediate products and sums are computed at full width before truncation.
REQ-006 Conductances update in every state, including REFRACT.
REQ-007 The next membrane value is v_next = clamp(floor(v*DECAY_V >> FRAC) + ge - gi, 0, 2^W-1). It uses the registered ge and gi, and negative results clamp to 0.
REQ-008 FSM states: INTEGRATE, FIRE, REFRACT. The reset state is INTEGRATE.
REQ-009 INTEGRATE: if v_next >= THRESHOLD, then v <= V_RESET, o_spike <= 1, and the FSM goes to FIRE. Otherwise v <= v_next.
REQ-010 FIRE lasts exactly one cycle with o_spike high and v held at V_RESET. The FSM then goes to REFRACT with the refractory counter loaded to T_REF, or to INTEGRATE if T_REF == 0.
REQ-011 REFRACT: v is held at V_RESET, o_refractory = 1 and the counter decrements each cycle. The FSM returns to INTEGRATE in the cycle after the counter reaches 1, so REFRACT lasts exactly T_REF cycles.
REQ-012 Latency: a spike sampled at edge k updates ge at edge k; its effect on v and any resulting fire appears at edge k+1. Input-to-o_spike latency is therefore 2 cycles.
REQ-013 o_spike is never high on two consecutive cycles.
REQ-014 o_spike_count increments on each fire, at the same edge o_spike rises, and wraps from 2^CNT_W-1 to 0.
REQ-015 While i_enable is low, ge, gi, v, the FSM state, the refractory counter and the spike counter all hold, and o_spike is driven 0. An interrupted FIRE resumes when i_enable returns high.
REQ-016 Simultaneous excitatory and inhibitory spikes are both applied in the same cycle; there is no priority between them.

Reset
REQ-017 When reset is low, asynchronously set: ge = gi = 0, v = V_RESET, state = INTEGRATE, refractory counter = 0, o_spike = 0, o_refractory = 0, o_spike_count = 0.
REQ-018 Reset asserted mid-REFRACT or mid-FIRE aborts the state immediately, with no residual pulse after release.

Structure
REQ-019 The state enum type and the default fixed-point constants (weights, decays, THRESHOLD) shall live in a shared package, neuron_pkg.
REQ-020 One sub-module, decay_accum, shall be instantiated twice, once for ge and once for gi. It is parametrised by decay factor, weight and input count, and implements the multiply-shift, popcount-weight and saturating add.

Verification (default parameters unless stated)
REQ-021 Assert reset, then release with no input: all outputs are 0 indefinitely.
REQ-022 Pulse i_excitatory[0] for one cycle: ge = 0x800, then 0x4D0; o_membrane = 0x800, then 0xC00; o_spike stays 0.
REQ-023 Drive all 8 excitatory inputs for one cycle: ge saturates to 0x3FFF and o_spike pulses once, 2 edges after sampling. o_membrane = 0, o_refractory is high for exactly 3 cycles, and o_spike_count = 1.
REQ-024 Drive identical excitatory and inhibitory patterns continuously: o_membrane stays 0 (clamped) and no fire occurs.
REQ-025 Assert reset during the second REFRACT cycle: all outputs are 0 immediately, and no spike follows release without new input.
REQ-026 With CNT_W = 2, force 5 fires: o_spike_count reads 1, 2, 3, 0, 1. A run with T_REF = 0 shows FIRE followed directly by INTEGRATE.
